// File: rtl/fifo_up_if.sv
// fifo_up_if: push/pop bus between the demux side, the FIFO and its downstream consumer
interface fifo_up_if #(
    parameter int DATA_SIZE = 10
);
    logic                 push;
    logic [DATA_SIZE-1:0] data_in;
    logic                 pop;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, err_overflow, err_underflow
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_up_almostfull.sv
// fifo_up_almostfull: single-clock FIFO after the 1:2 demux; FIFO_UP_FWFT_EN selects first-word-fall-through reads
module fifo_up_almostfull #(
    parameter int DATA_SIZE       = 10,
    parameter int ADDR_SIZE       = 2,
    parameter int ALMOST_FULL_TH  = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input logic     clk,
    input logic     reset,
    fifo_up_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE + 1)'(ALMOST_EMPTY_TH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic [ADDR_SIZE:0]   count;
    logic                 push_ok, pop_ok;

    assign bus.full         = count == DEPTH_C;
    assign bus.empty        = count == '0;
    assign bus.almost_full  = count >= AF_C;
    assign bus.almost_empty = count <= AE_C;
    assign push_ok          = bus.push & ~bus.full;
    assign pop_ok           = bus.pop & ~bus.empty;

    // Storage array; never reset, stale words are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= bus.data_in;
    end

    // Pointers, occupancy and single-cycle error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            bus.err_overflow  <= 1'b0;
            bus.err_underflow <= 1'b0;
        end else begin
            wr_ptr            <= push_ok ? wr_ptr + ADDR_SIZE'(1) : wr_ptr;
            rd_ptr            <= pop_ok ? rd_ptr + ADDR_SIZE'(1) : rd_ptr;
            count             <= count + (ADDR_SIZE + 1)'(push_ok) - (ADDR_SIZE + 1)'(pop_ok);
            bus.err_overflow  <= bus.push & bus.full;
            bus.err_underflow <= bus.pop & bus.empty;
        end
    end

`ifdef FIFO_UP_FWFT_EN
    // Head word is presented directly; pop only acknowledges it
    always_comb begin
        bus.data_out  = bus.empty ? '0 : mem[rd_ptr];
        bus.valid_out = ~bus.empty;
    end
`else
    // Registered read: popped word appears one cycle after the pop edge and is then held
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.data_out  <= pop_ok ? mem[rd_ptr] : bus.data_out;
            bus.valid_out <= pop_ok;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_up_almostfull.sv
// tb_fifo_up_almostfull: queue-model checker plus directed literal checks for fifo_up_almostfull
module tb_fifo_up_almostfull;
    localparam int DS = 10;
    localparam int DEPTH = 4;
`ifdef FIFO_UP_FWFT_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   armed = 1'b0;

    fifo_up_if #(.DATA_SIZE(DS)) bus ();

    fifo_up_almostfull #(
        .DATA_SIZE(DS), .ADDR_SIZE(2), .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DS-1:0] q[$];
    logic [DS-1:0] m_reg;
    logic          m_valid, m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: words live in a queue, decisions come from its size before the edge
    always @(posedge clk) begin : mdl
        int  n;
        bit  pu, po;
        n = q.size();
        if (reset) begin
            q.delete();
            m_reg = '0;
            m_valid = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pu = bus.push && n < DEPTH;
            po = bus.pop && n > 0;
            m_ovf = bus.push && n == DEPTH;
            m_unf = bus.pop && n == 0;
            m_valid = po;
            if (po) m_reg = q.pop_front();
            if (pu) q.push_back(bus.data_in);
        end
    end

    // Compare every DUT output against the model each cycle
    always @(negedge clk) begin : cmp
        int n;
        logic [DS-1:0] ed;
        if (armed) begin
            n = q.size();
            ed = m_reg;
            if (FW) begin
                ed = '0;
                if (n > 0) ed = q[0];
            end
            chk("full", 32'(bus.full), 32'(n == DEPTH));
            chk("empty", 32'(bus.empty), 32'(n == 0));
            chk("almost_full", 32'(bus.almost_full), 32'(n >= 3));
            chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 1));
            chk("data_out", 32'(bus.data_out), 32'(ed));
            chk("valid_out", 32'(bus.valid_out), FW ? 32'(n > 0) : 32'(m_valid));
            chk("err_overflow", 32'(bus.err_overflow), 32'(m_ovf));
            chk("err_underflow", 32'(bus.err_underflow), 32'(m_unf));
        end
    end

    task automatic step(input logic p, input logic [DS-1:0] d, input logic o);
        bus.push = p;
        bus.data_in = d;
        bus.pop = o;
        @(negedge clk);
    endtask

    initial begin
        bus.push = 1'b1;
        bus.data_in = 10'h3FF;
        bus.pop = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_ae", 32'(bus.almost_empty), 1);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.valid_out), 0);
        reset = 1'b0;
        step(0, 0, 0);
        chk("rst_nothing_stored", 32'(bus.empty), 1);

        step(1, 10'h001, 0);
        step(1, 10'h002, 0);
        chk("af_at2", 32'(bus.almost_full), 0);
        step(1, 10'h003, 0);
        chk("af_at3", 32'(bus.almost_full), 1);
        chk("full_at3", 32'(bus.full), 0);
        step(1, 10'h004, 0);
        chk("full_at4", 32'(bus.full), 1);
        step(1, 10'h005, 0);
        chk("ovf_pulse", 32'(bus.err_overflow), 1);
        step(0, 0, 0);
        chk("ovf_clear", 32'(bus.err_overflow), 0);

        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 1);
            chk("pop_dout", 32'(bus.data_out), FW ? (i < 4 ? i + 1 : 0) : i);
            chk("pop_valid", 32'(bus.valid_out), FW ? 32'(i < 4) : 1);
        end
        chk("drained_empty", 32'(bus.empty), 1);
        step(0, 0, 1);
        chk("unf_pulse", 32'(bus.err_underflow), 1);
        chk("unf_valid", 32'(bus.valid_out), 0);
        chk("unf_dout_hold", 32'(bus.data_out), FW ? 0 : 4);
        step(0, 0, 0);
        chk("unf_clear", 32'(bus.err_underflow), 0);

        step(1, 10'h010, 0);
        step(1, 10'h011, 0);
        for (int i = 2; i <= 9; i++) step(1, 10'(16 + i), 1);
        step(0, 0, 1);
        chk("wrap_dout_a", 32'(bus.data_out), FW ? 'h19 : 'h18);
        step(0, 0, 1);
        chk("wrap_dout_b", 32'(bus.data_out), FW ? 0 : 'h19);
        chk("wrap_empty", 32'(bus.empty), 1);

        step(1, 10'h0A1, 0);
        step(1, 10'h0A2, 0);
        step(1, 10'h0A3, 1);
        chk("pp2_ae", 32'(bus.almost_empty), 0);
        chk("pp2_af", 32'(bus.almost_full), 0);
        chk("pp2_dout", 32'(bus.data_out), FW ? 'h0A2 : 'h0A1);
        step(1, 10'h0A4, 0);
        step(1, 10'h0A5, 0);
        chk("ppf_full", 32'(bus.full), 1);
        step(1, 10'h0A6, 1);
        chk("ppf_ovf", 32'(bus.err_overflow), 1);
        chk("ppf_full_after", 32'(bus.full), 0);
        chk("ppf_dout", 32'(bus.data_out), FW ? 'h0A3 : 'h0A2);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("ppf_last", 32'(bus.data_out), FW ? 0 : 'h0A5);
        step(1, 10'h0A7, 1);
        chk("ppe_unf", 32'(bus.err_underflow), 1);
        chk("ppe_valid", 32'(bus.valid_out), FW ? 1 : 0);
        chk("ppe_stored", 32'(bus.empty), 0);
        step(0, 0, 1);
        chk("ppe_dout", 32'(bus.data_out), FW ? 0 : 'h0A7);

        step(1, 10'h0B1, 0);
        step(1, 10'h0B2, 0);
        step(1, 10'h0B3, 0);
        chk("mid_af", 32'(bus.almost_full), 1);
        reset = 1'b1;
        step(0, 0, 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_valid", 32'(bus.valid_out), 0);
        chk("mid_rst_af", 32'(bus.almost_full), 0);
        reset = 1'b0;
        step(1, 10'h155, 0);
        chk("post_push_valid", 32'(bus.valid_out), FW ? 1 : 0);
        if (FW) chk("post_push_dout", 32'(bus.data_out), 'h155);
        step(0, 0, 1);
        chk("post_pop_dout", 32'(bus.data_out), FW ? 0 : 'h155);
        chk("post_pop_valid", 32'(bus.valid_out), FW ? 0 : 1);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
